// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between a FIFO and the serial transmitter.
// The master modport is the FIFO side: it presents the empty flag and the head
// word, and it receives the pop strobe. The slave modport is the consumer side.
interface fifo_uart_tx_if #(
  parameter int B = 8
) ();
  logic         fifo_empty;
  logic [B-1:0] fifo_data;
  logic         fifo_rd;

  modport master (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd
  );

  modport slave (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a FIFO.
// Whenever the FIFO holds a word and the transmitter is free, it pops the word
// and sends it as a start bit, B data bits LSB first, and SB stop bits, with
// every bit lasting DIV clocks. If another word is waiting when the last stop
// bit ends, it is popped on that same edge, so consecutive frames have no gap.
// The interface width must match B.
module fifo_uart_tx #(
  parameter int B   = 8,
  parameter int DIV = 16,
  parameter int SB  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  fifo_uart_tx_if.slave   fifo,
  output logic            o_tx,
  output logic            o_busy,
  output logic            o_tx_done
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW = (B > 2) ? $clog2(B) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(B - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(SB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         r_state;
  logic [DW-1:0]  r_divCnt;
  logic [CW-1:0]  r_bitCnt;
  logic [B-1:0]   r_shreg;
  logic           r_tx;

  logic           w_divEnd;
  logic           w_stopEnd;
  logic           w_pop;
  logic [B-1:0]   w_shNext;

  assign w_divEnd  = (r_divCnt == DIV_LAST);
  assign w_stopEnd = (r_state == STOP) && (r_bitCnt == STOP_LAST) && w_divEnd;
  assign w_pop     = ~fifo.fifo_empty & ((r_state == IDLE) | w_stopEnd);
  assign w_shNext  = r_shreg >> 1;

  assign fifo.fifo_rd = w_pop;
  assign o_tx         = r_tx;
  assign o_busy       = (r_state != IDLE);
  assign o_tx_done    = w_stopEnd;

  // Frame sequencer: bit timing, data shifting, and the registered serial line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_divCnt <= '0;
      r_bitCnt <= '0;
      r_shreg  <= '0;
      r_tx     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx     <= 1'b1;
          r_divCnt <= '0;
          r_bitCnt <= '0;
          if (w_pop) begin
            r_shreg <= fifo.fifo_data;
            r_state <= START;
            r_tx    <= 1'b0;
          end
        end

        START: begin
          if (w_divEnd) begin
            r_divCnt <= '0;
            r_bitCnt <= '0;
            r_state  <= DATA;
            r_tx     <= r_shreg[0];
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        DATA: begin
          if (w_divEnd) begin
            r_divCnt <= '0;
            r_shreg  <= w_shNext;
            if (r_bitCnt == BIT_LAST) begin
              r_bitCnt <= '0;
              r_state  <= STOP;
              r_tx     <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
              r_tx     <= w_shNext[0];
            end
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        STOP: begin
          if (w_divEnd) begin
            r_divCnt <= '0;
            if (r_bitCnt == STOP_LAST) begin
              r_bitCnt <= '0;
              if (w_pop) begin
                r_shreg <= fifo.fifo_data;
                r_state <= START;
                r_tx    <= 1'b0;
              end else begin
                r_state <= IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_divCnt <= '0;
          r_bitCnt <= '0;
          r_tx     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx.
// Instance A (DIV=4, SB=1) is fed from a fall-through FIFO stub; every pushed
// word also goes into an expected-word queue. A monitor decodes the serial
// line frame by frame against an ideal waveform built from the word, and
// checks pop legality. Instance B (DIV=16, SB=2) covers the two-stop-bit frame.
module tb_fifo_uart_tx;

  localparam int B       = 8;
  localparam int DIVA    = 4;
  localparam int SBA     = 1;
  localparam int FRAME_A = (1 + B + SBA) * DIVA;
  localparam int DIVB    = 16;
  localparam int SBB     = 2;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running system clock, 10 time units per cycle.
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.B(B)) ifA ();
  fifo_uart_tx_if #(.B(B)) ifB ();

  logic txA, busyA, doneA;
  logic txB, busyB, doneB;

  fifo_uart_tx #(.B(B), .DIV(DIVA), .SB(SBA)) dutA (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .fifo      (ifA.slave),
    .o_tx      (txA),
    .o_busy    (busyA),
    .o_tx_done (doneA)
  );

  fifo_uart_tx #(.B(B), .DIV(DIVB), .SB(SBB)) dutB (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .fifo      (ifB.slave),
    .o_tx      (txB),
    .o_busy    (busyB),
    .o_tx_done (doneB)
  );

  int checkCount  = 0;
  int passCount   = 0;
  int wordsPushed = 0;

  logic [7:0] fifoQ[$];
  logic [7:0] expQ[$];
  bit         holdEmpty = 1'b0;

  int   cycleNo     = 0;
  int   lastRdCycle = -100;
  int   c           = 0;
  bit   inFrame     = 1'b0;
  logic [7:0] curExp = '0;
  logic [7:0] recv   = '0;
  int   shapeErr    = 0;
  int   idleErr     = 0;
  int   framesDone  = 0;
  int   frameStarts[$];

  // Records one comparison and reports it when the values differ.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
  endtask

  // Presents the FIFO head word, or random junk when empty so stale data is never reused.
  task automatic refreshA();
    ifA.fifo_empty = (fifoQ.size() == 0) || holdEmpty;
    ifA.fifo_data  = (fifoQ.size() > 0) ? fifoQ[0] : 8'($urandom);
  endtask

  // Pushes one word into the FIFO stub and records it as an expected frame.
  task automatic applyStimulus(input logic [7:0] w);
    fifoQ.push_back(w);
    expQ.push_back(w);
    wordsPushed++;
    refreshA();
  endtask

  // Waits (bounded) until the stub is drained and instance A is idle.
  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while ((fifoQ.size() != 0 || busyA || inFrame) && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drainWithinBudget", (n < maxCycles), 1);
    @(posedge clk);
    #2;
  endtask

  // FIFO stub: pops on the strobe at the clock edge, then updates its outputs.
  always @(posedge clk) begin
    if (ifA.fifo_rd && fifoQ.size() > 0) void'(fifoQ.pop_front());
    #1 refreshA();
  end

  // Monitor: decodes frames on tx, compares with the expected words, checks pops.
  always @(negedge clk) begin
    int   k;
    logic lvl;
    cycleNo++;
    if (!rst_n) begin
      inFrame = 1'b0;
    end else begin
      if (inFrame) c++;
      else if (txA == 1'b0) begin
        inFrame  = 1'b1;
        c        = 1;
        shapeErr = 0;
        recv     = '0;
        frameStarts.push_back(cycleNo);
        checkOutput("popToStartLatency", cycleNo - lastRdCycle, 1);
        if (expQ.size() > 0) curExp = expQ.pop_front();
        else begin
          curExp = '0;
          checkOutput("unexpectedFrame", 1, 0);
        end
      end
      if (inFrame) begin
        k   = (c - 1) / DIVA;
        lvl = (k == 0) ? 1'b0 : (k <= B) ? curExp[k-1] : 1'b1;
        if (txA !== lvl) shapeErr++;
        if (busyA !== 1'b1) shapeErr++;
        if (doneA !== (c == FRAME_A)) shapeErr++;
        if (((c - 1) % DIVA) == DIVA / 2 && k >= 1 && k <= B) recv[k-1] = txA;
      end else if (busyA !== 1'b0 || doneA !== 1'b0) begin
        idleErr++;
      end
      if (ifA.fifo_rd) begin
        checkOutput("rdWhileEmpty", ifA.fifo_empty, 0);
        checkOutput("rdOnlyIdleOrStopEnd", (!inFrame || c == FRAME_A), 1);
        lastRdCycle = cycleNo;
      end
      if (inFrame && c == FRAME_A) begin
        checkOutput("frameByte", recv, curExp);
        checkOutput("frameShape", shapeErr, 0);
        framesDone++;
        inFrame = 1'b0;
      end
    end
  end

  // Hard stop in case something stalls the whole simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, idle, fixed words, back-to-back, reset mid-frame, SB=2, random.
  initial begin
    int   errs;
    int   n;
    int   doneAt;
    int   base;
    bit   done6;
    logic expTx;

    rst_n = 1'b0;
    refreshA();
    ifB.fifo_empty = 1'b1;
    ifB.fifo_data  = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetTxA", txA, 1);
    checkOutput("resetBusyA", busyA, 0);
    checkOutput("resetDoneA", doneA, 0);
    checkOutput("resetRdA", ifA.fifo_rd, 0);
    checkOutput("resetTxB", txB, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txA !== 1'b1 || ifA.fifo_rd !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0) errs++;
    end
    checkOutput("T1idleErrors", errs, 0);
    @(posedge clk);
    #2;

    applyStimulus(8'h55);
    waitIdle(200);

    base = frameStarts.size();
    applyStimulus(8'hA3);
    applyStimulus(8'h0F);
    waitIdle(300);
    checkOutput("T3frameCount", frameStarts.size() - base, 2);
    if (frameStarts.size() - base == 2)
      checkOutput("T3backToBackGap", frameStarts[base+1] - frameStarts[base], FRAME_A);

    ifB.fifo_data  = 8'h00;
    ifB.fifo_empty = 1'b0;
    @(negedge clk);
    checkOutput("T4pop", ifB.fifo_rd, 1);
    @(posedge clk);
    #1;
    ifB.fifo_empty = 1'b1;
    ifB.fifo_data  = 8'hFF;
    errs   = 0;
    doneAt = -1;
    for (int cy = 1; cy <= 180; cy++) begin
      @(negedge clk);
      expTx = (cy <= (1 + B) * DIVB) ? 1'b0 : 1'b1;
      if (txB !== expTx) errs++;
      if (busyB !== (cy <= (1 + B + SBB) * DIVB)) errs++;
      if (doneB === 1'b1 && doneAt < 0) doneAt = cy;
      if (ifB.fifo_rd !== 1'b0) errs++;
    end
    checkOutput("T4waveErrors", errs, 0);
    checkOutput("T4doneCycle", doneAt, (1 + B + SBB) * DIVB);
    @(posedge clk);
    #2;

    applyStimulus(8'($urandom));
    n = 0;
    while (!(inFrame && c == 15) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("T5reachedClk15", (n < 100), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("T5asyncTx", txA, 1);
    checkOutput("T5asyncBusy", busyA, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifA.fifo_rd !== 1'b0 || txA !== 1'b1 || busyA !== 1'b0) errs++;
    end
    checkOutput("T5quietAfterRelease", errs, 0);
    @(posedge clk);
    #2;

    done6 = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(1, 50)) @(posedge clk);
          #2 applyStimulus(8'($urandom));
        end
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          @(posedge clk);
          #2;
          if ($urandom_range(0, 7) == 0) begin
            holdEmpty = ~holdEmpty;
            refreshA();
          end
        end
      end
    join
    @(posedge clk);
    #2;
    holdEmpty = 1'b0;
    refreshA();
    waitIdle(3000);

    checkOutput("expectedQueueDrained", expQ.size(), 0);
    checkOutput("idleLevelErrors", idleErr, 0);
    checkOutput("framesCompleted", framesDone, wordsPushed - 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
